// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressable data memory for the MIPS MEM stage: 1-cycle loads, RMW sub-word
// stores, alignment checks. Define DMEM_INIT_CLEAR_EN to zero the array after reset.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        AlignErr,
    output logic        Busy,
    output logic [31:0] dMemOut
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_read_data;
    logic [31:0]           r_dmem_out;
    logic                  r_read_valid;
    logic                  r_align_err;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_ready;
    logic                  w_busy;
    logic                  w_misalign;
    logic                  w_do_read;
    logic                  w_do_write;
    logic                  w_align_err;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic [31:0]           w_load;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_sweep_we;
    logic [DEPTH_LOG2-1:0] w_sweep_idx;
    logic                  w_mem_we;
    logic [DEPTH_LOG2-1:0] w_mem_idx;
    logic [31:0]           w_mem_wdata;
    logic                  w_unused_addr;

    // Upper address bits are deliberately ignored so addresses alias modulo the array size.
    assign w_unused_addr = ^Address[31:DEPTH_LOG2+2];
    assign w_idx         = Address[DEPTH_LOG2+1:2];
    assign w_off         = Address[1:0];

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic {StClear, StReady} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DEPTH_LOG2-1:0] r_sweep_idx;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= StClear;
            r_sweep_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StClear) begin
                r_sweep_idx <= r_sweep_idx + DEPTH_LOG2'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        unique case (r_state)
            StClear: begin
                w_busy = 1'b1;
                if (r_sweep_idx == {DEPTH_LOG2{1'b1}}) begin
                    w_state_next = StReady;
                end
            end
            StReady: w_state_next = StReady;
        endcase
    end

    assign w_ready     = ~Reset & ~w_busy;
    assign w_sweep_we  = ~Reset & w_busy;
    assign w_sweep_idx = r_sweep_idx;
`else
    assign w_busy      = 1'b0;
    assign w_ready     = ~Reset;
    assign w_sweep_we  = 1'b0;
    assign w_sweep_idx = '0;
`endif

    assign Busy = w_busy;

    // Size 11 falls into the word rules via Size[1].
    assign w_misalign  = ((Size == 2'b01) && Address[0]) || (Size[1] && (w_off != 2'b00));
    assign w_align_err = w_ready & (MemRead | MemWrite) & w_misalign;
    assign w_do_write  = w_ready & MemWrite & ~w_misalign;
    assign w_do_read   = w_ready & MemRead & ~MemWrite & ~w_misalign;

    assign w_old = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        w_byte   = w_old[7:0];
        w_half   = w_off[1] ? w_old[15:0] : w_old[31:16];
        case (w_off)
            2'b00:   w_byte = w_old[31:24];
            2'b01:   w_byte = w_old[23:16];
            2'b10:   w_byte = w_old[15:8];
            default: w_byte = w_old[7:0];
        endcase
        case (Size)
            2'b00: begin
                case (w_off)
                    2'b00:   w_merged = {WriteData[7:0], w_old[23:0]};
                    2'b01:   w_merged = {w_old[31:24], WriteData[7:0], w_old[15:0]};
                    2'b10:   w_merged = {w_old[31:16], WriteData[7:0], w_old[7:0]};
                    default: w_merged = {w_old[31:8], WriteData[7:0]};
                endcase
                w_load = Unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_merged = w_off[1] ? {w_old[31:16], WriteData[15:0]}
                                    : {WriteData[15:0], w_old[15:0]};
                w_load   = Unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: begin
                w_merged = WriteData;
                w_load   = w_old;
            end
        endcase
    end

    // Single write port shared by the clear sweep and stores; they are mutually exclusive.
    assign w_mem_we    = w_sweep_we | w_do_write;
    assign w_mem_idx   = w_sweep_we ? w_sweep_idx : w_idx;
    assign w_mem_wdata = w_sweep_we ? 32'b0 : w_merged;

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_align_err  <= 1'b0;
            r_dmem_out   <= '0;
        end else begin
            r_read_valid <= w_do_read;
            r_align_err  <= w_align_err;
            if (w_do_read) begin
                r_read_data <= w_load;
            end
            if (w_do_write) begin
                r_dmem_out <= w_merged;
            end
        end
    end

    assign ReadData  = r_read_data;
    assign ReadValid = r_read_valid;
    assign AlignErr  = r_align_err;
    assign dMemOut   = r_dmem_out;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl; load results go through an expected-value queue.
// Sweep checks are compiled only when DMEM_INIT_CLEAR_EN is defined.
module tb_data_mem_ctrl;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        AlignErr;
    logic        Busy;
    logic [31:0] dMemOut;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.DEPTH_LOG2(6)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .AlignErr  (AlignErr),
        .Busy      (Busy),
        .dMemOut   (dMemOut)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        Size      = 2'b10;
        Unsigned  = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        MemRead   = rd;
        MemWrite  = wr;
        Address   = a;
        WriteData = wd;
        Size      = sz;
        Unsigned  = uns;
        step();
        idle();
    endtask

    task automatic test_reset();
        int cnt;
        logic [31:0] e;
        idle();
        Reset = 1'b1;
        step();
        step();
        n_tests++;
        if (ReadData !== 32'h0 || ReadValid !== 1'b0 || AlignErr !== 1'b0 || dMemOut !== 32'h0)
        begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%h v=%b ae=%b dmo=%h exp all zero",
                     ReadData, ReadValid, AlignErr, dMemOut);
        end
        Reset = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
        cnt = 0;
        while (Busy === 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
        n_tests++;
        if (cnt !== 64) begin
            n_fail++;
            $display("FAIL busy_len got=%0d exp=64", cnt);
        end
        exp_q.push_back(32'h0);
        issue(1'b1, 1'b0, 32'h3c, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL lw_cleared got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
        last_rd = e;
`else
        n_tests++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_off got=%b exp=0", Busy);
        end
        last_rd = 32'h0;
`endif
    endtask

    task automatic test_word();
        logic [31:0] e;
        issue(1'b0, 1'b1, 32'h10, 32'hfeedbeef, 2'b10, 1'b0);
        n_tests++;
        if (dMemOut !== 32'hfeedbeef || ReadValid !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_dmemout got=%h v=%b exp=feedbeef v=0", dMemOut, ReadValid);
        end
        exp_q.push_back(32'hfeedbeef);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL lw_word got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
        last_rd = e;
        step();
        n_tests++;
        if (ReadValid !== 1'b0 || ReadData !== last_rd) begin
            n_fail++;
            $display("FAIL idle_hold got v=%b d=%h exp v=0 d=%h", ReadValid, ReadData, last_rd);
        end
    endtask

    task automatic test_subword();
        logic [31:0] a_tab [7] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h10, 32'h11};
        logic [1:0]  s_tab [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        u_tab [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] e_tab [7] = '{32'hffffff8f, 32'h0000008f, 32'h00004b4f, 32'h0000be8f,
                                   32'hffffbe8f, 32'h0000004b, 32'h0000004f};
        logic [31:0] e;
        issue(1'b0, 1'b1, 32'h13, 32'h0000008f, 2'b00, 1'b0);
        n_tests++;
        if (dMemOut !== 32'hfeedbe8f) begin
            n_fail++;
            $display("FAIL sb_merge got=%h exp=feedbe8f", dMemOut);
        end
        issue(1'b0, 1'b1, 32'h10, 32'h00004b4f, 2'b01, 1'b0);
        n_tests++;
        if (dMemOut !== 32'h4b4fbe8f) begin
            n_fail++;
            $display("FAIL sh_merge got=%h exp=4b4fbe8f", dMemOut);
        end
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(e_tab[i]);
            issue(1'b1, 1'b0, a_tab[i], 32'h0, s_tab[i], u_tab[i]);
            e = exp_q.pop_front();
            n_tests++;
            if (ReadValid !== 1'b1 || ReadData !== e) begin
                n_fail++;
                $display("FAIL subword_load%0d got v=%b d=%h exp v=1 d=%h",
                         i, ReadValid, ReadData, e);
            end
            last_rd = e;
        end
    endtask

    task automatic test_align();
        logic [31:0] e;
        issue(1'b0, 1'b1, 32'h11, 32'h0000aaaa, 2'b01, 1'b0);
        n_tests++;
        if (AlignErr !== 1'b1 || ReadValid !== 1'b0 || dMemOut !== 32'h4b4fbe8f) begin
            n_fail++;
            $display("FAIL sh_misalign got ae=%b v=%b dmo=%h exp ae=1 v=0 dmo=4b4fbe8f",
                     AlignErr, ReadValid, dMemOut);
        end
        step();
        n_tests++;
        if (AlignErr !== 1'b0) begin
            n_fail++;
            $display("FAIL ae_pulse got=%b exp=0", AlignErr);
        end
        issue(1'b1, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0);
        n_tests++;
        if (AlignErr !== 1'b1 || ReadValid !== 1'b0 || ReadData !== last_rd) begin
            n_fail++;
            $display("FAIL lw_misalign got ae=%b v=%b d=%h exp ae=1 v=0 d=%h",
                     AlignErr, ReadValid, ReadData, last_rd);
        end
        exp_q.push_back(32'h4b4fbe8f);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e || AlignErr !== 1'b0 || dMemOut !== e) begin
            n_fail++;
            $display("FAIL after_misalign got v=%b d=%h ae=%b dmo=%h exp v=1 d=%h ae=0",
                     ReadValid, ReadData, AlignErr, dMemOut, e);
        end
        last_rd = e;
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        issue(1'b0, 1'b1, 32'h100, 32'h00000001, 2'b10, 1'b0);
        exp_q.push_back(32'h00000001);
        issue(1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL wrap_alias got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
        exp_q.push_back(32'h00000001);
        issue(1'b1, 1'b0, 32'hffff_ff00, 32'h0, 2'b11, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL size11_load got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
        last_rd = e;
    endtask

    task automatic test_both();
        logic [31:0] e;
        issue(1'b1, 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0);
        n_tests++;
        if (ReadValid !== 1'b0 || dMemOut !== 32'h12345678 || ReadData !== last_rd) begin
            n_fail++;
            $display("FAIL rd_wr_both got v=%b dmo=%h d=%h exp v=0 dmo=12345678 d=%h",
                     ReadValid, dMemOut, ReadData, last_rd);
        end
        exp_q.push_back(32'h12345678);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL both_stored got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
        last_rd = e;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 32'ha5a5a5a5 ^ (32'h01010101 * i);
            issue(1'b0, 1'b1, 32'h40 + 4 * i, v, 2'b10, 1'b0);
            exp_q.push_back(v);
            issue(1'b1, 1'b0, 32'h40 + 4 * i, 32'h0, 2'b10, 1'b0);
            e = exp_q.pop_front();
            n_tests++;
            if (ReadValid !== 1'b1 || ReadData !== e) begin
                n_fail++;
                $display("FAIL raw_fwd%0d got v=%b d=%h exp v=1 d=%h", i, ReadValid, ReadData, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'ha5a5a5a5 ^ (32'h01010101 * i));
            issue(1'b1, 1'b0, 32'h40 + 4 * i, 32'h0, 2'b10, 1'b0);
            e = exp_q.pop_front();
            n_tests++;
            if (ReadValid !== 1'b1 || ReadData !== e) begin
                n_fail++;
                $display("FAIL b2b_load%0d got v=%b d=%h exp v=1 d=%h", i, ReadValid, ReadData, e);
            end
            last_rd = e;
        end
    endtask

`ifdef DMEM_INIT_CLEAR_EN
    task automatic test_reset_mid_sweep();
        int   cnt;
        logic spurious;
        logic [31:0] e;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 30; i++) step();
        Reset = 1'b1;
        step();
        Reset    = 1'b0;
        MemRead  = 1'b1;
        Address  = 32'h11;
        cnt      = 0;
        spurious = 1'b0;
        while (Busy === 1'b1 && cnt < 200) begin
            MemRead = ~MemRead;
            Address = MemRead ? 32'h11 : 32'h20;
            step();
            cnt++;
            spurious = spurious | ReadValid | AlignErr;
        end
        idle();
        n_tests++;
        if (cnt !== 64) begin
            n_fail++;
            $display("FAIL sweep_restart_len got=%0d exp=64", cnt);
        end
        n_tests++;
        if (spurious !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_ignores_req got=%b exp=0", spurious);
        end
        exp_q.push_back(32'h0);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL sweep_cleared got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
    endtask
`else
    task automatic test_reset_persist();
        logic [31:0] e;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_tests++;
        if (Busy !== 1'b0 || dMemOut !== 32'h0 || ReadData !== 32'h0) begin
            n_fail++;
            $display("FAIL rereset got busy=%b dmo=%h d=%h exp 0 0 0", Busy, dMemOut, ReadData);
        end
        exp_q.push_back(32'h12345678);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (ReadValid !== 1'b1 || ReadData !== e) begin
            n_fail++;
            $display("FAIL mem_survives got v=%b d=%h exp v=1 d=%h", ReadValid, ReadData, e);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        Reset   = 1'b1;
        last_rd = 32'h0;
        idle();
        test_reset();
        test_word();
        test_subword();
        test_align();
        test_wrap();
        test_both();
        test_back_to_back();
`ifdef DMEM_INIT_CLEAR_EN
        test_reset_mid_sweep();
`else
        test_reset_persist();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
